// File: rtl/alu_ctrl_exec.sv
// Decode-and-execute ALU stage with valid/ready handshakes and a registered result.
// Define ALU_MULDIV_EN to add the iterative multi-cycle MUL/DIV/REM datapath.
module alu_ctrl_exec #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      operation,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  if (XLEN < 8) begin : g_bad_xlen
    $error("alu_ctrl_exec: XLEN must be at least 8");
  end
  if (CNT_W < SHW + 1) begin : g_bad_cnt_w
    $error("alu_ctrl_exec: CNT_W too narrow to count XLEN iterations");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, HOLD} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110,
    OP_SLT  = 4'b0111, OP_SLL  = 4'b1000, OP_SRL = 4'b1001, OP_SRA = 4'b1010,
    OP_SLTU = 4'b1011, OP_XOR  = 4'b1100, OP_MUL = 4'b1101, OP_DIV = 4'b1110,
    OP_REM  = 4'b1111
  } op_t;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  state_t          state, state_n;
  op_t             dec_op;
  logic            dec_ill;
  logic [XLEN-1:0] alu_res;
  logic            accept;
  logic            r_type;
  logic [SHW-1:0]  shamt;

  assign accept = in_valid & in_ready;
  assign r_type = (alu_op == 2'b10);
  assign shamt  = op_b[SHW-1:0];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
    case (alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      default: begin
        if (r_type && funct7 == F7_MD) begin
`ifdef ALU_MULDIV_EN
          case (funct3)
            3'b000:  dec_op = OP_MUL;
            3'b100:  dec_op = OP_DIV;
            3'b110:  dec_op = OP_REM;
            default: dec_ill = 1'b1;
          endcase
`else
          dec_ill = 1'b1;
`endif
        end else if (r_type && funct7 != F7_BASE && funct7 != F7_ALT) begin
          dec_ill = 1'b1;
        end else begin
          case (funct3)
            3'b000:  dec_op = (r_type && funct7 == F7_ALT) ? OP_SUB : OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = (funct7 == F7_ALT) ? OP_SRA : OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_SLL:  alu_res = op_a << shamt;
      OP_SRL:  alu_res = op_a >> shamt;
      OP_SRA:  alu_res = $signed(op_a) >>> shamt;
      OP_XOR:  alu_res = op_a ^ op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  // md_acc is the product accumulator for MUL and the partial remainder for DIV/REM;
  // md_q is the multiplier for MUL and the dividend/quotient shift register for DIV/REM.
  logic [XLEN-1:0] md_acc, md_b, md_q, md_a, md_final;
  logic [XLEN:0]   md_shift, md_trial;
  logic [CNT_W-1:0] cnt;
  logic            md_neg_q, md_neg_r, md_dz, is_md;

  assign is_md    = (dec_op == OP_MUL) || (dec_op == OP_DIV) || (dec_op == OP_REM);
  assign md_shift = {md_acc, md_q[XLEN-1]};
  assign md_trial = md_shift - {1'b0, md_b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      md_acc   <= '0;
      md_b     <= '0;
      md_q     <= '0;
      md_a     <= '0;
      md_neg_q <= 1'b0;
      md_neg_r <= 1'b0;
      md_dz    <= 1'b0;
    end else if (accept && is_md) begin
      cnt    <= '0;
      md_acc <= '0;
      md_a   <= op_a;
      if (dec_op == OP_MUL) begin
        md_b     <= op_a;
        md_q     <= op_b;
        md_neg_q <= 1'b0;
        md_neg_r <= 1'b0;
        md_dz    <= 1'b0;
      end else begin
        md_b     <= op_b[XLEN-1] ? -op_b : op_b;
        md_q     <= op_a[XLEN-1] ? -op_a : op_a;
        md_neg_q <= op_a[XLEN-1] ^ op_b[XLEN-1];
        md_neg_r <= op_a[XLEN-1];
        md_dz    <= (op_b == '0);
      end
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      if (operation == OP_MUL) begin
        if (md_q[0]) md_acc <= md_acc + md_b;
        md_b <= md_b << 1;
        md_q <= md_q >> 1;
      end else if (!md_trial[XLEN]) begin
        md_acc <= md_trial[XLEN-1:0];
        md_q   <= {md_q[XLEN-2:0], 1'b1};
      end else begin
        md_acc <= md_shift[XLEN-1:0];
        md_q   <= {md_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Sign fix-up and the divide-by-zero special case, applied on the FIX edge.
  always_comb begin
    md_final = md_acc;
    case (operation)
      OP_DIV:  md_final = md_dz ? '1 : (md_neg_q ? -md_q : md_q);
      OP_REM:  md_final = md_dz ? md_a : (md_neg_r ? -md_acc : md_acc);
      default: md_final = md_acc;
    endcase
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          state_n = HOLD;
`ifdef ALU_MULDIV_EN
          if (is_md) state_n = CALC;
`endif
        end else if (state == HOLD && out_ready) begin
          state_n = IDLE;
        end
      end
`ifdef ALU_MULDIV_EN
      CALC: if (cnt == CNT_LAST) state_n = FIX;
      FIX:  state_n = HOLD;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == HOLD);
    in_ready  = (state == IDLE) || (state == HOLD && out_ready);
  end

  // NOTE: every datapath register has an async reset; an in-flight result is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      operation <= '0;
      illegal   <= 1'b0;
    end else if (accept) begin
      result    <= dec_ill ? '0 : alu_res;
      operation <= dec_op;
      illegal   <= dec_ill;
`ifdef ALU_MULDIV_EN
    end else if (state == FIX) begin
      result <= md_final;
`endif
    end
  end

endmodule
